// File: rtl/pc_unit_stack.sv
// Program counter with next-PC select (seq/branch/jump/call/ret) and a circular return-address stack; one-cycle latency, stall holds all state.
// Optional sticky stack overflow/underflow flags (err_ovf/err_udf) are built when PC_STACK_ERR_EN is defined.
module pc_unit_stack #(
  parameter int              PC_W      = 8,
  parameter int              OFF_W     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic [OFF_W-1:0]           rel_off,
  input  logic [PC_W-1:0]            abs_target,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_next,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty
`ifdef PC_STACK_ERR_EN
  ,
  output logic                       err_ovf,
  output logic                       err_udf
`endif
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [PC_W-1:0]        ras [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          wr_ptr_inc;
  logic [PW-1:0]          top_idx;
  logic [PC_W-1:0]        seq;
  logic signed [PC_W-1:0] off_ext;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        pc_sel;
  logic                   do_push;
  logic                   do_pop;

  assign stack_full  = (depth == DW'(DEPTH));
  assign stack_empty = (depth == '0);

  assign seq     = pc + PC_W'(1);
  assign off_ext = PC_W'($signed(rel_off));
  assign br_tgt  = seq + off_ext;

  // wr_ptr names the slot the next push lands in; when full that slot is the oldest entry
  assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign top_idx    = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);

  assign do_push = !stall && (op == OP_CALL);
  assign do_pop  = !stall && (op == OP_RET) && !stack_empty;

  always_comb begin
    pc_sel = seq;
    if (stall) begin
      pc_sel = pc;
    end else begin
      case (op)
        OP_NEXT:   pc_sel = seq;
        OP_BRANCH: pc_sel = cond ? br_tgt : seq;
        OP_JUMP:   pc_sel = abs_target;
        OP_CALL:   pc_sel = abs_target;
        OP_RET:    pc_sel = stack_empty ? seq : ras[top_idx];
        default:   pc_sel = seq;
      endcase
    end
  end

  assign pc_next = rst ? RESET_VEC : pc_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      depth  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr_inc;
      if (!stack_full) begin
        depth <= depth + DW'(1);
      end
    end else if (do_pop) begin
      wr_ptr <= top_idx;
      depth  <= depth - DW'(1);
    end
  end

  // Entry contents are meaningless once depth is cleared, so the array carries no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras[wr_ptr] <= seq;
    end
  end

`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (do_push && stack_full) begin
        err_ovf <= 1'b1;
      end
      if (!stall && (op == OP_RET) && stack_empty) begin
        err_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit_stack.sv
// Directed checks of pc_unit_stack: reset, sequencing, branches, wrap, nested calls, RAS overflow/underflow, stall, async reset.
module tb_pc_unit_stack;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [2:0] op;
  logic       cond;
  logic [7:0] rel_off;
  logic [7:0] abs_target;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
`ifdef PC_STACK_ERR_EN
  logic       err_ovf;
  logic       err_udf;
`endif

  int total = 0;
  int bad   = 0;

  pc_unit_stack #(.PC_W(8), .OFF_W(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .op          (op),
    .cond        (cond),
    .rel_off     (rel_off),
    .abs_target  (abs_target),
    .pc          (pc),
    .pc_next     (pc_next),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
`ifdef PC_STACK_ERR_EN
    ,
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one rising edge pass, return 1 time unit after it
  task automatic step(input logic [2:0] o, input logic c, input logic [7:0] off, input logic [7:0] tgt);
    op         = o;
    cond       = c;
    rel_off    = off;
    abs_target = tgt;
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] NXT = 3'd0;
  localparam logic [2:0] BRA = 3'd1;
  localparam logic [2:0] JMP = 3'd2;
  localparam logic [2:0] CAL = 3'd3;
  localparam logic [2:0] RET = 3'd4;

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    op         = NXT;
    cond       = 1'b0;
    rel_off    = 8'h00;
    abs_target = 8'h00;
    #3;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_pc_next", 32'(pc_next), 32'h00);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(stack_empty), 32'd1);
    check("rst_full", 32'(stack_full), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_pc", 32'(pc), 32'h00);
    rst = 1'b0;
    #1;
    check("pc_next_seq", 32'(pc_next), 32'h01);

    // Sequential fetch
    step(NXT, 1'b0, 8'h00, 8'h00); check("next1", 32'(pc), 32'h01);
    step(NXT, 1'b0, 8'h00, 8'h00); check("next2", 32'(pc), 32'h02);
    step(NXT, 1'b0, 8'h00, 8'h00); check("next3", 32'(pc), 32'h03);
    check("next_depth", 32'(depth), 32'd0);
    check("next_empty", 32'(stack_empty), 32'd1);
    op = 3'd6;
    #1;
    check("op6_as_next", 32'(pc_next), 32'h04);

    // Branches
    step(JMP, 1'b0, 8'h00, 8'h10); check("jump10", 32'(pc), 32'h10);
    step(BRA, 1'b1, 8'h03, 8'h00); check("br_taken", 32'(pc), 32'h14);
    step(JMP, 1'b0, 8'h00, 8'h10);
    step(BRA, 1'b0, 8'h03, 8'h00); check("br_not_taken", 32'(pc), 32'h11);
    step(JMP, 1'b0, 8'h00, 8'h10);
    step(BRA, 1'b1, 8'hF0, 8'h00); check("br_neg16", 32'(pc), 32'h01);
    step(JMP, 1'b0, 8'h00, 8'h02);
    step(BRA, 1'b1, 8'hF8, 8'h00); check("br_neg8_wrap", 32'(pc), 32'hFB);

    // Wrap-around
    step(JMP, 1'b0, 8'h00, 8'hFE);
    step(NXT, 1'b0, 8'h00, 8'h00); check("wrap_ff", 32'(pc), 32'hFF);
    step(NXT, 1'b0, 8'h00, 8'h00); check("wrap_00", 32'(pc), 32'h00);

    // Nested calls
    step(JMP, 1'b0, 8'h00, 8'h05);
    step(CAL, 1'b0, 8'h00, 8'h40); check("call1_pc", 32'(pc), 32'h40);
    check("call1_depth", 32'(depth), 32'd1);
    step(CAL, 1'b0, 8'h00, 8'h80); check("call2_pc", 32'(pc), 32'h80);
    check("call2_depth", 32'(depth), 32'd2);
    step(RET, 1'b0, 8'h00, 8'h00); check("ret1_pc", 32'(pc), 32'h41);
    step(RET, 1'b0, 8'h00, 8'h00); check("ret2_pc", 32'(pc), 32'h06);
    check("ret2_depth", 32'(depth), 32'd0);

    // Overflow then underflow
    step(JMP, 1'b0, 8'h00, 8'h00);
    step(CAL, 1'b0, 8'h00, 8'h10);
    step(CAL, 1'b0, 8'h00, 8'h20);
    step(CAL, 1'b0, 8'h00, 8'h30);
    check("pre_full", 32'(stack_full), 32'd0);
    step(CAL, 1'b0, 8'h00, 8'h50);
    check("full_after4", 32'(stack_full), 32'd1);
    check("depth4", 32'(depth), 32'd4);
`ifdef PC_STACK_ERR_EN
    check("ovf_clear_before", 32'(err_ovf), 32'd0);
`endif
    step(CAL, 1'b0, 8'h00, 8'h60); check("call5_pc", 32'(pc), 32'h60);
    check("depth_sat", 32'(depth), 32'd4);
`ifdef PC_STACK_ERR_EN
    check("ovf_set", 32'(err_ovf), 32'd1);
`endif
    step(RET, 1'b0, 8'h00, 8'h00); check("oret1", 32'(pc), 32'h51);
    step(RET, 1'b0, 8'h00, 8'h00); check("oret2", 32'(pc), 32'h31);
    step(RET, 1'b0, 8'h00, 8'h00); check("oret3", 32'(pc), 32'h21);
    step(RET, 1'b0, 8'h00, 8'h00); check("oret4", 32'(pc), 32'h11);
    check("oret4_empty", 32'(stack_empty), 32'd1);
`ifdef PC_STACK_ERR_EN
    check("udf_clear_before", 32'(err_udf), 32'd0);
`endif
    step(RET, 1'b0, 8'h00, 8'h00); check("oret5_udf", 32'(pc), 32'h12);
    check("oret5_depth", 32'(depth), 32'd0);
`ifdef PC_STACK_ERR_EN
    check("udf_set", 32'(err_udf), 32'd1);
    step(NXT, 1'b0, 8'h00, 8'h00);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    check("udf_sticky", 32'(err_udf), 32'd1);
    step(JMP, 1'b0, 8'h00, 8'h12);
`endif

    // Stall
    stall = 1'b1;
    op = CAL;
    abs_target = 8'h77;
    #1;
    check("stall_pc_next", 32'(pc_next), 32'h12);
    step(CAL, 1'b0, 8'h00, 8'h77); check("stall_call_pc", 32'(pc), 32'h12);
    check("stall_call_depth", 32'(depth), 32'd0);
    stall = 1'b0;
    step(CAL, 1'b0, 8'h00, 8'h70); check("call70", 32'(pc), 32'h70);
    stall = 1'b1;
    step(RET, 1'b0, 8'h00, 8'h00); check("stall_ret_pc", 32'(pc), 32'h70);
    check("stall_ret_depth", 32'(depth), 32'd1);
    stall = 1'b0;

    // Async reset between edges, with a pending return address
    op = NXT;
    #1;
    rst = 1'b1;
    #1;
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_depth", 32'(depth), 32'd0);
    check("arst_pc_next", 32'(pc_next), 32'h00);
`ifdef PC_STACK_ERR_EN
    check("arst_ovf", 32'(err_ovf), 32'd0);
    check("arst_udf", 32'(err_udf), 32'd0);
`endif
    rst = 1'b0;
    step(RET, 1'b0, 8'h00, 8'h00); check("ret_after_rst", 32'(pc), 32'h01);
    check("ret_after_rst_depth", 32'(depth), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
